// File: rtl/mipsfpga_ahb_bcdconv.sv
// mipsfpga_ahb_bcdconv
// Converts an unsigned binary value into eight BCD digits plus a digit
// disable mask. The outputs feed the seven-segment timer's DISP0..DISP7
// and EN inputs directly. The conversion uses double dabble (shift-add-3)
// and processes one input bit per clock.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        conversion request (accepted when not converting)
//   bin          binary value, captured on the accepted start
//   blank        leading-zero blanking enable, captured with bin
//   busy         high while a conversion is in progress
//   done         one-cycle pulse when new outputs are valid
//   ovf          last converted value exceeded 99_999_999
//   EN           digit disables, bit i = 1 turns digit i off
//   DISP0..DISP7 BCD digits, DISP0 is the least significant
module mipsfpga_ahb_bcdconv #(
    parameter int unsigned BIN_W = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [7:0]       EN,
    output logic [3:0]       DISP0,
    output logic [3:0]       DISP1,
    output logic [3:0]       DISP2,
    output logic [3:0]       DISP3,
    output logic [3:0]       DISP4,
    output logic [3:0]       DISP5,
    output logic [3:0]       DISP6,
    output logic [3:0]       DISP7
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    localparam logic [31:0] MAX_DEC  = 32'd99_999_999;
    localparam logic [4:0]  LAST_BIT = 5'(BIN_W - 1);
    localparam logic [7:0]  EN_RESET = 8'hFE;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [31:0]        acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               blank_q, blank_d;
    logic               big_q, big_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         en_q, en_d;
    logic [31:0]        disp_q, disp_d;

    logic [31:0]        acc_adj;
    logic [32+BIN_W-1:0] pair_shift;
    logic [31:0]        load_digits;
    logic [7:0]         load_en;
    int unsigned        msd;
    logic               capture;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
        pair_shift = {acc_adj, shift_q} << 1;
    end

    // Digits and disable mask presented at the LOAD edge. Out-of-range
    // values saturate to all nines, which makes the mask all-enabled.
    always_comb begin
        load_digits = big_q ? {8{4'd9}} : acc_q;
        load_en     = '0;
        msd         = 0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (load_digits[i*4 +: 4] != 4'd0) begin
                msd = i;
            end
        end
        if (blank_q) begin
            for (int unsigned i = 0; i < 8; i++) begin
                load_en[i] = (i > msd);
            end
        end
    end

    // A start is also honoured on the LOAD edge so that a held start
    // converts every BIN_W+1 cycles; busy then stays high across it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        big_d   = big_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        en_d    = en_q;
        disp_d  = disp_q;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                capture = start;
            end
            SHIFT: begin
                {acc_d, shift_d} = pair_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_BIT) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = load_digits;
                en_d    = load_en;
                ovf_d   = big_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                capture = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            shift_d = bin;
            blank_d = blank;
            big_d   = (32'(bin) > MAX_DEC);
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            big_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= EN_RESET;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            big_q   <= big_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            disp_q  <= disp_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign EN    = en_q;
    assign DISP0 = disp_q[3:0];
    assign DISP1 = disp_q[7:4];
    assign DISP2 = disp_q[11:8];
    assign DISP3 = disp_q[15:12];
    assign DISP4 = disp_q[19:16];
    assign DISP5 = disp_q[23:20];
    assign DISP6 = disp_q[27:24];
    assign DISP7 = disp_q[31:28];

endmodule
